// File: rtl/io_out_fifo.sv
// Buffers processor OUT writes as {addr, data} entries and drains them in write order over valid/ready.
// Latency 1 cycle write-to-head; a write to a full buffer without a same-cycle pop is dropped and flags ovf.
// Optional IO_OUT_DROP_CNT_EN adds a saturating drop_cnt, cleared by ovf_clr.
module io_out_fifo #(
    parameter int NUBITS = 16,
    parameter int NBIOOU = 2,
    parameter int FDEPTH = 8,
    parameter int DCNTW  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUBITS-1:0]         io_out,
    input  logic [NBIOOU-1:0]         addr_out,
    input  logic                      out_en,
    input  logic                      flush,
    output logic [NUBITS-1:0]         m_data,
    output logic [NBIOOU-1:0]         m_addr,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(FDEPTH):0]   level,
    output logic                      full,
    output logic                      empty,
    output logic                      ovf,
    input  logic                      ovf_clr
`ifdef IO_OUT_DROP_CNT_EN
    ,
    output logic [DCNTW-1:0]          drop_cnt
`endif
);
    localparam int AW = $clog2(FDEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [NBIOOU-1:0] addr;
        logic [NUBITS-1:0] data;
    } entry_t;

    generate
        if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0 || DCNTW < 1) begin : g_bad_param
            $error("io_out_fifo: FDEPTH must be a power of two >= 2 and DCNTW >= 1");
        end
    endgenerate

    entry_t          mem [FDEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            push;
    logic            pop;
    logic            drop;
    entry_t          head;

    assign full    = (level == LW'(FDEPTH));
    assign empty   = (level == '0);
    assign m_valid = !empty;
    assign head    = mem[rp];
    assign m_data  = head.data;
    assign m_addr  = head.addr;

    assign pop  = m_valid && m_ready;
    assign push = out_en && (!full || pop);
    assign drop = out_en && full && !pop;

    // Storage is not reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wp] <= '{addr: addr_out, data: io_out};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Set wins over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef IO_OUT_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            drop_cnt <= drop ? DCNTW'(1) : '0;
        end else if (drop && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DCNTW'(1);
        end
    end
`endif

endmodule

// File: doc/io_out_fifo.md
# io_out_fifo

Output-port buffer between the processor core's output interface and external peripherals. Each processor `OUT` write (`out_en` pulse with `addr_out`/`io_out`) is captured as one `{addr, data}` entry in a circular FIFO. Entries drain through a valid/ready stream, so slow peripherals never lose samples while the buffer has room. The processor cannot stall, so writes to a full buffer are dropped and flagged.

## Interface
- `NUBITS`, 16, data word width; equals the processor's `NUBITS`.
- `NBIOOU`, 2, output port address width; equals the processor's `NBIOOU`.
- `FDEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `DCNTW`, 8, drop counter width (used only with `IO_OUT_DROP_CNT_EN`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `io_out`  in  NUBITS  word written by the processor.
- `addr_out`  in  NBIOOU  destination port of the write.
- `out_en`  in  1  write strobe, one cycle per `OUT` instruction.
- `flush`  in  1  synchronous discard of all entries.
- `m_data`  out  NUBITS  head entry data.
- `m_addr`  out  NBIOOU  head entry port address.
- `m_valid`  out  1  head entry present.
- `m_ready`  in  1  consumer accepts the head this cycle.
- `level`  out  $clog2(FDEPTH)+1  number of stored entries.
- `full`  out  1  `level == FDEPTH`.
- `empty`  out  1  `level == 0`.
- `ovf`  out  1  sticky drop flag.
- `ovf_clr`  in  1  clears `ovf`.
- `drop_cnt`  out  DCNTW  dropped-write count (only with `IO_OUT_DROP_CNT_EN`).

## Operation
- **Storage.** `FDEPTH` × (`NBIOOU`+`NUBITS`) register array, write pointer `wp`, read pointer `rp`, and a separate `level` counter. Pointers are `$clog2(FDEPTH)` bits and wrap from `FDEPTH`-1 to 0.
- **Events.**
  - push = `out_en && (!full || pop)`.
  - pop = `m_valid && m_ready`.
  - drop = `out_en && full && !pop`.
- **Push.** Write `{addr_out, io_out}` at `wp`, then `wp++`.
- **Pop.** `rp++`.
- **Level.** `level` is +1 on push only, −1 on pop only, and unchanged when push and pop occur together.
- **Head outputs.** `m_data`/`m_addr` = `mem[rp]` (combinational read). `m_valid` = `!empty`. While `m_valid` = 0, `m_data`/`m_addr` are don't-care.
- **Flush.** Sets `wp`, `rp` and `level` to 0. Any push or pop in the same cycle is ignored. `ovf` and `drop_cnt` are not affected.
- **Overflow flag.** `ovf` is set on drop and cleared on `ovf_clr`. When both occur in the same cycle, set wins.
- **Empty buffer.** A pop cannot occur when empty, because `m_valid` = 0.
- **Reset values.** `wp`, `rp`, `level` = 0; `m_valid` = 0, `empty` = 1, `full` = 0, `ovf` = 0, `drop_cnt` = 0. Array contents are not reset. Asserting reset mid-stream discards all entries immediately.

## Timing
- Write latency is 1 cycle: an `out_en` sampled at edge k into an empty FIFO gives `m_valid` = 1 after edge k, with the entry on `m_data`.
- A pop at edge k presents the next entry (or `m_valid` = 0) after edge k.
- With `m_ready` held at 1, the FIFO sustains one push and one pop per cycle.
- `full`, `empty` and `level` are registered-state derived and change only after a clock edge (or on reset).
- The consumer holds `m_ready` independently of `m_valid`. `m_data`/`m_addr` stay stable while `m_valid` = 1 and `m_ready` = 0.
- Entries drain in strict write order, regardless of port address.

## Configuration
- **Macro:** `IO_OUT_DROP_CNT_EN`.
- **Defined:**
  - The `drop_cnt` port and a `DCNTW`-bit counter exist.
  - The counter increments on each drop and saturates at all-ones.
  - `ovf_clr` also zeroes it; if `ovf_clr` and a drop occur in the same cycle, the result is 1.
- **Undefined:** the `drop_cnt` port and counter are absent. Only the sticky `ovf` reports drops.

## Test plan
- **Reset:** assert `rst`=0 mid-stream with 3 entries stored → `m_valid`=0, `empty`=1, `level`=0, `ovf`=0 immediately, without waiting for a clock edge.
- **Single write:** `out_en` with `addr_out`=2, `io_out`=16'h1234, `m_ready`=0 → next cycle `m_valid`=1, `m_addr`=2, `m_data`=16'h1234, `level`=1; hold 5 cycles → all stable.
- **Fill and drop:** with `FDEPTH`=8 and `m_ready`=0, write 0..9 → `full`=1 after the 8th write; writes 8 and 9 are dropped, `ovf`=1, `drop_cnt`=2 (macro on). Then `m_ready`=1 → reads 0..7 in order, then `empty`=1.
- **Full with simultaneous pop:** `full`=1, `out_en` with value 16'hAAAA and `m_ready`=1 in the same cycle → no drop, `level` stays 8, and 16'hAAAA comes out last.
- **Wrap-around streaming:** `m_ready`=1 and 20 consecutive writes 0..19 → output sequence 0..19 with no gaps, `level` ≤ 1 throughout, pointers wrap twice.
- **Flush vs. overflow clear:** `flush` with 5 entries stored, together with an `out_en` → `level`=0 and the new word is discarded. Then `ovf_clr` coinciding with a drop → `ovf` stays 1 and `drop_cnt`=1.
